// File: rtl/throw_power_meter.sv
// Charge-and-release throw power meter: ramps power while the serving player
// holds the left button, freezes it on release and flags the throw until end_throw.
module throw_power_meter #(
  parameter int POWER_W     = 4,
  parameter int STEP_CYCLES = 2820000,
  parameter int MIN_POWER   = 0,
  parameter int MAX_POWER   = 15,
  parameter int MODE        = 0,
  parameter int PID_W       = 2
) (
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic               left,
  input  logic [PID_W-1:0]   turn,
  input  logic [PID_W-1:0]   current_player,
  input  logic               end_throw,
  input  logic               abort,
  output logic [POWER_W-1:0] power,
  output logic               throw_flag,
  output logic               charging,
  output logic               release_pulse,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0]      STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [POWER_W-1:0] MIN_P     = POWER_W'(MIN_POWER);
  localparam logic [POWER_W-1:0] MAX_P     = POWER_W'(MAX_POWER);

  typedef enum logic [1:0] {IDLE = 2'd0, CHARGE = 2'd1, HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [POWER_W-1:0] power_q, power_d, power_step;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dir_down_q, dir_down_d, dir_step;
  logic               armed_q, armed_d;
  logic               flag_q, flag_d;
  logic               pulse_q, pulse_d;
  logic               my_turn;

  assign my_turn = (turn == current_player);

  // Next power value for one ramp step; never leaves [MIN_P, MAX_P].
  always_comb begin
    power_step = power_q;
    dir_step   = dir_down_q;
    case (MODE)
      1: power_step = (power_q == MAX_P) ? MIN_P : power_q + 1'b1;
      2: begin
        if (!dir_down_q) begin
          if (power_q == MAX_P) begin
            dir_step   = 1'b1;
            power_step = power_q - 1'b1;
          end else begin
            power_step = power_q + 1'b1;
          end
        end else begin
          if (power_q == MIN_P) begin
            dir_step   = 1'b0;
            power_step = power_q + 1'b1;
          end else begin
            power_step = power_q - 1'b1;
          end
        end
      end
      default: if (power_q != MAX_P) power_step = power_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    armed_d    = armed_q;
    flag_d     = 1'b0;
    pulse_d    = 1'b0;
    case (state_q)
      IDLE: begin
        power_d = '0;
        if (!left) begin
          armed_d = 1'b1;
        end else if (my_turn && armed_q && !abort) begin
          state_d    = CHARGE;
          power_d    = MIN_P;
          cnt_d      = '0;
          dir_down_d = 1'b0;
          armed_d    = 1'b0;
        end
      end
      CHARGE: begin
        if (abort || !my_turn) begin
          state_d = IDLE;
          power_d = '0;
          cnt_d   = '0;
        end else if (!left) begin
          // A step falling due on the release cycle is dropped.
          state_d = HOLD;
          cnt_d   = '0;
          flag_d  = 1'b1;
          pulse_d = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d      = '0;
          power_d    = power_step;
          dir_down_d = dir_step;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (end_throw) begin
          state_d = IDLE;
          power_d = '0;
        end else begin
          flag_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        power_d    = '0;
        cnt_d      = '0;
        dir_down_d = 1'b0;
        armed_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      power_q    <= '0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      armed_q    <= 1'b1;
      flag_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      armed_q    <= armed_d;
      flag_q     <= flag_d;
      pulse_q    <= pulse_d;
    end
  end

  assign power         = power_q;
  assign throw_flag    = flag_q;
  assign release_pulse = pulse_q;
  assign charging      = (state_q == CHARGE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_throw_power_meter.sv
// Directed bench for throw_power_meter: four parameterisations share one
// stimulus stream; each scenario checks the instance it targets.
module tb_throw_power_meter;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0;
  logic [1:0] turn = 2'd0;
  logic [1:0] current_player = 2'd0;
  logic       end_throw = 1'b0;
  logic       abort = 1'b0;

  // a: STEP=4 saturate; b: STEP=1 saturate; c: 2-bit wrap; d: 2-bit ping-pong
  logic [3:0] a_power, b_power;
  logic [1:0] c_power, d_power;
  logic       a_flag, a_chg, a_pulse, b_flag, b_chg, b_pulse;
  logic       c_flag, c_chg, c_pulse, d_flag, d_chg, d_pulse;
  logic [1:0] a_st, b_st, c_st, d_st;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk60MHz = ~clk60MHz;

  throw_power_meter #(.POWER_W(4), .STEP_CYCLES(4), .MIN_POWER(0), .MAX_POWER(15),
                      .MODE(0), .PID_W(2)) u_a (
    .clk60MHz(clk60MHz), .rst(rst), .left(left), .turn(turn),
    .current_player(current_player), .end_throw(end_throw), .abort(abort),
    .power(a_power), .throw_flag(a_flag), .charging(a_chg),
    .release_pulse(a_pulse), .state_dbg(a_st));

  throw_power_meter #(.POWER_W(4), .STEP_CYCLES(1), .MIN_POWER(0), .MAX_POWER(15),
                      .MODE(0), .PID_W(2)) u_b (
    .clk60MHz(clk60MHz), .rst(rst), .left(left), .turn(turn),
    .current_player(current_player), .end_throw(end_throw), .abort(abort),
    .power(b_power), .throw_flag(b_flag), .charging(b_chg),
    .release_pulse(b_pulse), .state_dbg(b_st));

  throw_power_meter #(.POWER_W(2), .STEP_CYCLES(1), .MIN_POWER(0), .MAX_POWER(3),
                      .MODE(1), .PID_W(2)) u_c (
    .clk60MHz(clk60MHz), .rst(rst), .left(left), .turn(turn),
    .current_player(current_player), .end_throw(end_throw), .abort(abort),
    .power(c_power), .throw_flag(c_flag), .charging(c_chg),
    .release_pulse(c_pulse), .state_dbg(c_st));

  throw_power_meter #(.POWER_W(2), .STEP_CYCLES(1), .MIN_POWER(0), .MAX_POWER(3),
                      .MODE(2), .PID_W(2)) u_d (
    .clk60MHz(clk60MHz), .rst(rst), .left(left), .turn(turn),
    .current_player(current_player), .end_throw(end_throw), .abort(abort),
    .power(d_power), .throw_flag(d_flag), .charging(d_chg),
    .release_pulse(d_pulse), .state_dbg(d_st));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk60MHz);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; left = 1'b0; turn = 2'd0; current_player = 2'd0;
    end_throw = 1'b0; abort = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    check("rst_power", a_power, 0);
    check("rst_flag", a_flag, 0);
    check("rst_charging", a_chg, 0);
    check("rst_pulse", a_pulse, 0);
    check("rst_state", a_st, 0);

    // Basic charge/release, STEP=4: 10 charge cycles -> power 2
    left = 1'b1;
    step();
    check("t1_charging_lat", a_chg, 1);
    check("t1_power_min", a_power, 0);
    step(9);
    check("t1_power_pre_rel", a_power, 2);
    left = 1'b0;
    step();
    check("t1_flag", a_flag, 1);
    check("t1_pulse_first", a_pulse, 1);
    check("t1_power_frozen", a_power, 2);
    check("t1_not_charging", a_chg, 0);
    step();
    check("t1_pulse_once", a_pulse, 0);
    check("t1_flag_hold", a_flag, 1);
    check("t1_power_hold", a_power, 2);
    end_throw = 1'b1;
    step();
    end_throw = 1'b0;
    check("t1_end_flag", a_flag, 0);
    check("t1_end_power", a_power, 0);
    check("t1_end_state", a_st, 0);

    // Saturation with STEP=1
    do_reset();
    left = 1'b1;
    step(16);
    check("t2_power_15", b_power, 15);
    step(24);
    check("t2_power_sat", b_power, 15);
    left = 1'b0;
    step();
    check("t2_frozen", b_power, 15);
    check("t2_flag", b_flag, 1);
    check("t2_pulse", b_pulse, 1);

    // Wrap and ping-pong sequences
    do_reset();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(1);
    left = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t3_wrap_%0d", i), c_power, exp_q.pop_front());
    end
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    left = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t3_pingpong_%0d", i), d_power, exp_q.pop_front());
    end

    // Not my turn, turn change mid-charge, abort mid-charge
    do_reset();
    turn = 2'd1;
    left = 1'b1;
    step(3);
    check("t4_other_turn_chg", a_chg, 0);
    check("t4_other_turn_pwr", a_power, 0);
    turn = 2'd0;
    step();
    check("t4_my_turn_chg", a_chg, 1);
    step(5);
    check("t4_pre_turn_pwr", a_power, 1);
    turn = 2'd2;
    step();
    check("t4_turnchg_chg", a_chg, 0);
    check("t4_turnchg_pwr", a_power, 0);
    check("t4_turnchg_flag", a_flag, 0);
    turn = 2'd0;
    step();
    check("t4_no_retrigger", a_chg, 0);
    left = 1'b0;
    step();
    left = 1'b1;
    step();
    check("t4_rearm_chg", a_chg, 1);
    step(5);
    check("t4_pre_abort_pwr", a_power, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_chg", a_chg, 0);
    check("t4_abort_pwr", a_power, 0);
    check("t4_abort_flag", a_flag, 0);

    // Release exactly when a step is due; held button through end_throw
    do_reset();
    left = 1'b1;
    step(8);
    check("t5_pwr_before", a_power, 1);
    left = 1'b0;
    step();
    check("t5_frozen_1", a_power, 1);
    check("t5_flag", a_flag, 1);
    left = 1'b1;
    end_throw = 1'b1;
    step();
    end_throw = 1'b0;
    check("t5_end_flag", a_flag, 0);
    step(2);
    check("t5_held_no_chg", a_chg, 0);
    check("t5_held_pwr", a_power, 0);
    left = 1'b0;
    step();
    left = 1'b1;
    step();
    check("t5_rearmed_chg", a_chg, 1);

    // Reset during HOLD, then a fresh press
    do_reset();
    left = 1'b1;
    step(6);
    left = 1'b0;
    step();
    check("t6_in_hold", a_flag, 1);
    rst = 1'b1;
    step();
    check("t6_rst_flag", a_flag, 0);
    check("t6_rst_power", a_power, 0);
    check("t6_rst_chg", a_chg, 0);
    check("t6_rst_pulse", a_pulse, 0);
    check("t6_rst_state", a_st, 0);
    rst = 1'b0;
    left = 1'b1;
    step();
    check("t6_new_charge", a_chg, 1);
    check("t6_new_state", a_st, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
